// File: rtl/msg_sched_ctrl.sv
// SHA-256 message schedule sequencer: loads a 16-word block into the circular W buffer,
// expands W[16..NUM_ROUNDS-1] in place and streams every W[t] over a valid/ready handshake.
module msg_sched_ctrl #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] msg_data,
  input  logic        msg_valid,
  output logic        msg_ready,
  output logic [31:0] w_out,
  output logic [5:0]  w_idx,
  output logic        w_valid,
  input  logic        w_ready,
  output logic        busy,
  output logic        done,
  output logic [3:0]  ram_addr1,
  output logic [31:0] ram_din1,
  output logic        ram_we1,
  output logic [3:0]  ram_addr2,
  output logic [31:0] ram_din2,
  output logic        ram_we2,
  input  logic [31:0] ram_dout1,
  input  logic [31:0] ram_dout2
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RDA  = 3'd2,
    RDB  = 3'd3,
    CALC = 3'd4,
    OUT  = 3'd5,
    FIN  = 3'd6
  } state_t;

  localparam logic [6:0] LAST_T     = 7'(NUM_ROUNDS - 1);
  localparam logic [6:0] LOAD_WORDS = 7'd16;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 5'd3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 5'd10);
  endfunction

  state_t      state_r, state_s;
  logic [6:0]  t_r;
  logic [31:0] a_r, b_r;
  logic [31:0] w_out_r;
  logic [5:0]  w_idx_r;
  logic        w_valid_r;
  logic        busy_r, done_r;
  logic        load_open_s, in_acc_s, out_acc_s;

  // An input word is only taken while the output slot is free or draining this cycle
  assign load_open_s = (state_r == LOAD) && (t_r < LOAD_WORDS) && (!w_valid_r || w_ready);
  assign in_acc_s    = load_open_s && msg_valid;
  assign out_acc_s   = w_valid_r && w_ready;

  assign w_out    = w_out_r;
  assign w_idx    = w_idx_r;
  assign w_valid  = w_valid_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign ram_din2 = 32'd0;
  assign ram_we2  = 1'b0;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = LOAD;
        else       state_s = IDLE;
      end
      LOAD: begin
        if ((t_r == LOAD_WORDS) && out_acc_s) state_s = RDA;
        else                                  state_s = LOAD;
      end
      RDA:  state_s = RDB;
      RDB:  state_s = CALC;
      CALC: state_s = OUT;
      OUT: begin
        if (out_acc_s) state_s = (t_r == LAST_T) ? FIN : RDA;
        else           state_s = OUT;
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Buffer port and input-handshake outputs; RDA/RDB fetch W[t-2],W[t-7] then W[t-15],W[t-16]
  always_comb begin
    msg_ready = 1'b0;
    ram_addr1 = 4'd0;
    ram_addr2 = 4'd0;
    ram_din1  = 32'd0;
    ram_we1   = 1'b0;
    case (state_r)
      LOAD: begin
        msg_ready = load_open_s;
        ram_addr1 = t_r[3:0];
        ram_din1  = msg_data;
        ram_we1   = in_acc_s && rst_n;
      end
      RDA: begin
        ram_addr1 = t_r[3:0] - 4'd2;
        ram_addr2 = t_r[3:0] - 4'd7;
      end
      RDB: begin
        ram_addr1 = t_r[3:0] - 4'd15;
        ram_addr2 = t_r[3:0];
      end
      OUT: begin
        ram_addr1 = t_r[3:0];
        ram_din1  = w_out_r;
        ram_we1   = out_acc_s && rst_n;
      end
      default: begin
        msg_ready = 1'b0;
        ram_addr1 = 4'd0;
        ram_addr2 = 4'd0;
        ram_din1  = 32'd0;
        ram_we1   = 1'b0;
      end
    endcase
  end

  // Round counter, operand capture and registered output word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_r       <= 7'd0;
      a_r       <= 32'd0;
      b_r       <= 32'd0;
      w_out_r   <= 32'd0;
      w_idx_r   <= 6'd0;
      w_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      busy_r <= (state_s == LOAD) || (state_s == RDA) || (state_s == RDB) ||
                (state_s == CALC) || (state_s == OUT);
      done_r <= (state_s == FIN);
      case (state_r)
        IDLE: begin
          if (start) t_r <= 7'd0;
          else       t_r <= t_r;
        end
        LOAD: begin
          if (in_acc_s) begin
            w_out_r   <= msg_data;
            w_idx_r   <= t_r[5:0];
            w_valid_r <= 1'b1;
            t_r       <= t_r + 7'd1;
          end else if (out_acc_s) begin
            w_valid_r <= 1'b0;
          end else begin
            w_valid_r <= w_valid_r;
          end
        end
        RDB: begin
          a_r <= ram_dout1;
          b_r <= ram_dout2;
        end
        CALC: begin
          w_out_r   <= sig1(a_r) + b_r + sig0(ram_dout1) + ram_dout2;
          w_idx_r   <= t_r[5:0];
          w_valid_r <= 1'b1;
        end
        OUT: begin
          if (out_acc_s) begin
            w_valid_r <= 1'b0;
            t_r       <= t_r + 7'd1;
          end else begin
            w_valid_r <= 1'b1;
          end
        end
        default: begin
          t_r <= t_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_sched_ctrl.sv
// Randomised scoreboard bench for msg_sched_ctrl: a full-array SHA-256 schedule model fills
// the expected queue, and negedge monitors compare every accepted word and done pulse.
module tb_msg_sched_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, msg_valid, msg_ready, w_valid, w_ready, busy, done;
  logic        ram_we1, ram_we2;
  logic [31:0] msg_data, w_out, ram_din1, ram_din2, ram_dout1, ram_dout2;
  logic [5:0]  w_idx;
  logic [3:0]  ram_addr1, ram_addr2;

  logic        start20, mv20, mr20, wv20, wr20, busy20, done20, we1_20, we2_20;
  logic [31:0] md20, wo20, din1_20, din2_20, dout1_20, dout2_20;
  logic [5:0]  wi20;
  logic [3:0]  a1_20, a2_20;

  msg_sched_ctrl #(.NUM_ROUNDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg_data(msg_data), .msg_valid(msg_valid),
    .msg_ready(msg_ready), .w_out(w_out), .w_idx(w_idx), .w_valid(w_valid), .w_ready(w_ready),
    .busy(busy), .done(done), .ram_addr1(ram_addr1), .ram_din1(ram_din1), .ram_we1(ram_we1),
    .ram_addr2(ram_addr2), .ram_din2(ram_din2), .ram_we2(ram_we2),
    .ram_dout1(ram_dout1), .ram_dout2(ram_dout2));

  msg_sched_ctrl #(.NUM_ROUNDS(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .start(start20), .msg_data(md20), .msg_valid(mv20),
    .msg_ready(mr20), .w_out(wo20), .w_idx(wi20), .w_valid(wv20), .w_ready(wr20),
    .busy(busy20), .done(done20), .ram_addr1(a1_20), .ram_din1(din1_20), .ram_we1(we1_20),
    .ram_addr2(a2_20), .ram_din2(din2_20), .ram_we2(we2_20),
    .ram_dout1(dout1_20), .ram_dout2(dout2_20));

  // Dual-port buffers: 1-cycle read latency, old data on a same-cycle write
  logic [31:0] mem [16];
  logic [31:0] mem20 [16];
  always @(posedge clk) begin
    if (ram_we1) mem[ram_addr1] <= ram_din1;
    ram_dout1 <= mem[ram_addr1];
    ram_dout2 <= mem[ram_addr2];
    if (we1_20) mem20[a1_20] <= din1_20;
    dout1_20 <= mem20[a1_20];
    dout2_20 <= mem20[a2_20];
  end

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        exp20_q[$];
  logic [31:0] blk [16];
  logic [31:0] wm  [64];
  int          checks = 0, errors = 0;
  int          done_cnt = 0, done20_cnt = 0;
  int          cyc = 0;
  int          acc_cyc [64];
  int          last20 = -1;
  bit          rdy_rand = 1'b0, force_low = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_out = 32'd0;
  logic [5:0]  prev_idx = 6'd0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straight FIPS 180-4 recurrence over the full 64-entry array
  task automatic build_model();
    for (int i = 0; i < 16; i++) wm[i] = blk[i];
    for (int i = 16; i < 64; i++)
      wm[i] = (rotr(wm[i-2], 17) ^ rotr(wm[i-2], 19) ^ (wm[i-2] >> 10)) + wm[i-7] +
              (rotr(wm[i-15], 7) ^ rotr(wm[i-15], 18) ^ (wm[i-15] >> 3)) + wm[i-16];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected();
    build_model();
    for (int i = 0; i < 64; i++) exp_q.push_back(exp_t'{idx: 6'(i), data: wm[i]});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input bit gaps);
    int i, n;
    i = 0;
    n = 0;
    while (i < 16 && n < 3000) begin
      msg_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      msg_data  = blk[i];
      @(negedge clk);
      if (msg_valid && msg_ready) i++;
      step();
      n++;
    end
    msg_valid = 1'b0;
    check("feed_complete", 64'(i), 64'd16);
  endtask

  task automatic run_block(input bit gaps, input bit glitch);
    int d0, n;
    push_expected();
    d0 = done_cnt;
    pulse_start();
    fork
      feed(gaps);
      begin
        if (glitch) begin
          repeat (5) step();
          start = 1'b1;
          @(negedge clk);
          check("busy_at_load_glitch", 64'(busy), 64'd1);
          step();
          start = 1'b0;
          repeat (60) step();
          start = 1'b1;
          @(negedge clk);
          check("busy_at_expand_glitch", 64'(busy), 64'd1);
          step();
          start = 1'b0;
        end
      end
    join
    n = 0;
    while (done_cnt == d0 && n < 4000) begin
      step();
      n++;
    end
    repeat (3) step();
    check("done_pulse_count", 64'(done_cnt - d0), 64'd1);
  endtask

  // w_ready driver: held high, 50% random, or forced low
  initial begin
    w_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      w_ready = force_low ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Main monitor: scoreboard pop, stall stability, busy/done consistency
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_valid", 64'(w_valid), 64'd1);
        check("stall_w_out", 64'(w_out), 64'(prev_out));
        check("stall_w_idx", 64'(w_idx), 64'(prev_idx));
      end
      if (w_valid) check("busy_while_valid", 64'(busy), 64'd1);
      if (w_valid && w_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got idx %0d data 0x%0h expected none", w_idx, w_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (w_idx !== e.idx || w_out !== e.data) begin
            errors++;
            $display("FAIL word: got idx %0d data 0x%08h expected idx %0d data 0x%08h",
                     w_idx, w_out, e.idx, e.data);
          end
        end
        acc_cyc[w_idx] = cyc;
      end
      if (done) begin
        done_cnt++;
        check("done_queue_empty", 64'(exp_q.size()), 64'd0);
        check("busy_low_at_done", 64'(busy), 64'd0);
      end
    end
    prev_stall = rst_n && w_valid && !w_ready;
    prev_out   = w_out;
    prev_idx   = w_idx;
  end

  // Monitor for the short NUM_ROUNDS=20 instance
  always @(negedge clk) begin
    if (rst_n && wv20 && wr20) begin
      checks++;
      if (exp20_q.size() == 0) begin
        errors++;
        $display("FAIL r20_unexpected_word: got idx %0d expected none", wi20);
      end else begin
        exp_t e;
        e = exp20_q.pop_front();
        if (wi20 !== e.idx || wo20 !== e.data) begin
          errors++;
          $display("FAIL r20_word: got idx %0d data 0x%08h expected idx %0d data 0x%08h",
                   wi20, wo20, e.idx, e.data);
        end
      end
      last20 = int'(wi20);
    end
    if (rst_n && done20) begin
      done20_cnt++;
      check("r20_last_idx", 64'(last20), 64'd19);
      check("r20_queue_empty", 64'(exp20_q.size()), 64'd0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n, i20;
    rst_n = 1'b0; start = 1'b0; msg_valid = 1'b0; msg_data = 32'd0;
    start20 = 1'b0; mv20 = 1'b0; md20 = 32'd0; wr20 = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("rst_w_valid", 64'(w_valid), 64'd0);
    check("rst_w_out", 64'(w_out), 64'd0);
    check("rst_w_idx", 64'(w_idx), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_msg_ready", 64'(msg_ready), 64'd0);
    check("rst_ram_we1", 64'(ram_we1), 64'd0);
    check("rst_ram_addr", 64'({ram_addr1, ram_addr2}), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // "abc" padded block, w_ready high
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0] = 32'h61626380;
    blk[15] = 32'h00000018;
    rdy_rand = 1'b0;
    run_block(1'b0, 1'b0);

    // All-zero block
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    run_block(1'b0, 1'b0);

    // "abc" again and a random block under random w_ready and msg_valid gaps
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0] = 32'h61626380;
    blk[15] = 32'h00000018;
    rdy_rand = 1'b1;
    run_block(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    run_block(1'b1, 1'b0);

    // Reset while word 40 is stalled in OUT, then a clean block
    rdy_rand = 1'b0;
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    push_expected();
    d0 = done_cnt;
    pulse_start();
    fork
      feed(1'b0);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!(w_valid && w_ready && w_idx == 6'd39) && n < 3000);
        force_low = 1'b1;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!(w_valid && w_idx == 6'd40) && n < 100);
        check("stalled_at_idx40", 64'({w_valid, w_idx}), 64'({1'b1, 6'd40}));
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_w_valid", 64'(w_valid), 64'd0);
      end
    join
    repeat (20) step();
    check("no_done_after_reset", 64'(done_cnt), 64'(d0));
    exp_q.delete();
    force_low = 1'b0;
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    run_block(1'b1, 1'b0);

    // start pulses during LOAD and during expansion are ignored
    rdy_rand = 1'b1;
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    run_block(1'b1, 1'b1);

    // Full throughput: 1 word/clk on load, 4 clk per expanded word
    rdy_rand = 1'b0;
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    run_block(1'b0, 1'b0);
    for (int i = 1; i < 64; i++)
      check($sformatf("spacing_idx%0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), (i < 16) ? 64'd1 : 64'd4);

    // NUM_ROUNDS=20 instance: 20 words then done
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    build_model();
    for (int i = 0; i < 20; i++) exp20_q.push_back(exp_t'{idx: 6'(i), data: wm[i]});
    start20 = 1'b1;
    step();
    start20 = 1'b0;
    i20 = 0;
    n = 0;
    while (i20 < 16 && n < 1000) begin
      mv20 = 1'b1;
      md20 = blk[i20];
      @(negedge clk);
      if (mv20 && mr20) i20++;
      step();
      n++;
    end
    mv20 = 1'b0;
    n = 0;
    while (done20_cnt == 0 && n < 1000) begin
      step();
      n++;
    end
    repeat (3) step();
    check("r20_done_count", 64'(done20_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
